aes_round_ctrl: RTL and testbench

Iterative AES-128 encryption sequencer between the UART receive/transmit framing and the combinational round datapath (sub-bytes, shift-rows, mix-columns, add-round-key). It accepts one 128-bit block, applies the initial AddRoundKey and then runs rounds 1 through 10 over a single state register. It fetches each round key by index from the key-schedule store and presents the ciphertext on a valid/ready output handshake. One block is in flight at a time.

---
 rtl/aes_round_ctrl.sv | 168 ++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: initial AddRoundKey, then rounds 1..NR over one state register.
// Optional macro AES_SPLIT_ROUND_EN: each round takes two cycles (SubBytes/ShiftRows, then MixColumns/AddRoundKey).
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         key_ready,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_t;

  localparam logic [3:0] LAST_RND = 4'(NR);

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  fsm_t         r_fsm;
  fsm_t         w_fsm_next;
  logic [3:0]   r_rnd;
  logic [3:0]   w_rnd_next;
  logic [127:0] r_state;
  logic [127:0] w_state_next;
  logic [127:0] w_sr;
  logic [127:0] w_mc_in;
  logic [127:0] w_mc;
`ifdef AES_SPLIT_ROUND_EN
  logic         r_phase;
  logic         w_phase_next;

  assign w_mc_in = r_state;
`else
  assign w_mc_in = w_sr;
`endif

  // Byte gi sits at row gi%4 of column gi/4; ShiftRows pulls row r from column (c+r)%4.
  for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
    localparam int COL = gi / 4;
    localparam int ROW = gi % 4;
    localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
    assign w_sr[8*gi +: 8] = sbox(r_state[8*SRC +: 8]);
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_mc_in[32*gi      +: 8];
    assign w_a1 = w_mc_in[32*gi + 8  +: 8];
    assign w_a2 = w_mc_in[32*gi + 16 +: 8];
    assign w_a3 = w_mc_in[32*gi + 24 +: 8];
    assign w_mc[32*gi      +: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign w_mc[32*gi + 8  +: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
    assign w_mc[32*gi + 16 +: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
    assign w_mc[32*gi + 24 +: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm   <= S_IDLE;
      r_rnd   <= '0;
      r_state <= '0;
`ifdef AES_SPLIT_ROUND_EN
      r_phase <= 1'b0;
`endif
    end else begin
      r_fsm   <= w_fsm_next;
      r_rnd   <= w_rnd_next;
      r_state <= w_state_next;
`ifdef AES_SPLIT_ROUND_EN
      r_phase <= w_phase_next;
`endif
    end
  end

  always_comb begin
    w_fsm_next   = r_fsm;
    w_rnd_next   = r_rnd;
    w_state_next = r_state;
`ifdef AES_SPLIT_ROUND_EN
    w_phase_next = r_phase;
`endif
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    rk_idx       = 4'd0;
    case (r_fsm)
      S_IDLE: begin
        in_ready = key_ready & ~rst;
        if (in_valid && in_ready) begin
          w_fsm_next   = S_ROUND;
          w_state_next = in_data ^ rk_in;
          w_rnd_next   = 4'd1;
        end
      end
      S_ROUND: begin
        busy   = 1'b1;
        rk_idx = r_rnd;
`ifdef AES_SPLIT_ROUND_EN
        if (!r_phase) begin
          w_state_next = w_sr;
          w_phase_next = 1'b1;
        end else begin
          w_state_next = ((r_rnd == LAST_RND) ? r_state : w_mc) ^ rk_in;
          w_phase_next = 1'b0;
          if (r_rnd == LAST_RND) begin
            w_fsm_next = S_DONE;
          end else begin
            w_rnd_next = r_rnd + 4'd1;
          end
        end
`else
        w_state_next = ((r_rnd == LAST_RND) ? w_sr : w_mc) ^ rk_in;
        if (r_rnd == LAST_RND) begin
          w_fsm_next = S_DONE;
        end else begin
          w_rnd_next = r_rnd + 4'd1;
        end
`endif
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_fsm_next = S_IDLE;
        end
      end
      default: begin
        w_fsm_next = S_IDLE;
      end
    endcase
  end

  assign out_data = r_state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: FIPS-197 vectors, backpressure, key gating, mid-block reset, back-to-back.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         key_ready;
  logic [3:0]   rk_idx;
  logic [127:0] rk_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int total = 0;
  int bad   = 0;

`ifdef AES_SPLIT_ROUND_EN
  localparam int PH = 2;
`else
  localparam int PH = 1;
`endif
  localparam int LAT    = 10 * PH;
  localparam int PERIOD = LAT + 2;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic [127:0] rk_tab [0:10];
  logic [7:0]   sb [0:255];

  always #5 clk = ~clk;

  assign rk_in = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : '0;

  aes_round_ctrl #(.NR(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key_ready(key_ready), .rk_idx(rk_idx), .rk_in(rk_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  // FIPS strings are written byte 0 first; the bus carries byte 0 in the low bits.
  function automatic logic [127:0] brev(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key_fips);
    logic [31:0]  w [0:43];
    logic [127:0] k;
    logic [31:0]  t;
    logic [7:0]   rcon;
    k = brev(key_fips);
    rcon = 8'h01;
    for (int j = 0; j < 4; j++) w[j] = k[32*j +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[7:0], t[31:8]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[7:0] = t[7:0] ^ rcon;
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one block through the accept edge and counts edges until out_valid (capped).
  task automatic accept_and_wait(input logic [127:0] pt_fips, output int n);
    in_data  = brev(pt_fips);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; key_ready = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    tick(); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (rk_idx !== 4'd0) begin bad++; $display("FAIL reset_rk_idx: got %0d want 0", rk_idx); end
    total++; if (out_data !== 128'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    $display("test_reset: checked reset outputs");
  endtask

  task automatic test_fips_b();
    int n;
    expand_key(KEY_B);
    accept_and_wait(PT_B, n);
    total++; if (n !== LAT) begin bad++; $display("FAIL fips_b_latency: got %0d want %0d", n, LAT); end
    total++; if (out_data !== brev(CT_B)) begin bad++; $display("FAIL fips_b_data: got %h want %h", brev(out_data), CT_B); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fips_b_busy_done: got %b want 1", busy); end
    tick();
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL fips_b_return_idle: got busy=%b ov=%b want 0 0", busy, out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fips_b_in_ready: got %b want 1", in_ready); end
    $display("test_fips_b: latency=%0d out=%h", n, brev(out_data));
  endtask

  task automatic test_fips_c1();
    logic [3:0] seq [$];
    logic [3:0] want [$];
    int n;
    expand_key(KEY_C);
    for (int r = 1; r <= 10; r++) for (int p = 0; p < PH; p++) want.push_back(4'(r));
    in_data  = brev(PT_C);
    in_valid = 1'b1;
    total++; if (rk_idx !== 4'd0) begin bad++; $display("FAIL c1_rk_idx_accept: got %0d want 0", rk_idx); end
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      seq.push_back(rk_idx);
      tick();
      n++;
    end
    total++; if (seq.size() !== want.size()) begin bad++; $display("FAIL c1_rk_seq_len: got %0d want %0d", seq.size(), want.size()); end
    for (int i = 0; i < seq.size() && i < want.size(); i++) begin
      total++; if (seq[i] !== want[i]) begin bad++; $display("FAIL c1_rk_seq[%0d]: got %0d want %0d", i, seq[i], want[i]); end
    end
    total++; if (out_data !== brev(CT_C)) begin bad++; $display("FAIL c1_data: got %h want %h", brev(out_data), CT_C); end
    total++; if (rk_idx !== 4'd0) begin bad++; $display("FAIL c1_rk_idx_done: got %0d want 0", rk_idx); end
    tick();
    $display("test_fips_c1: rk steps=%0d out=%h", seq.size(), brev(out_data));
  endtask

  task automatic test_backpressure();
    int n;
    logic [127:0] held;
    expand_key(KEY_B);
    out_ready = 1'b0;
    accept_and_wait(PT_B, n);
    held = out_data;
    total++; if (held !== brev(CT_B)) begin bad++; $display("FAIL bp_data: got %h want %h", brev(held), CT_B); end
    in_data  = brev(PT_C);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", c, out_valid); end
      total++; if (out_data !== held) begin bad++; $display("FAIL bp_stable[%0d]: got %h want %h", c, out_data, held); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_no_accept_on_release: got busy=%b want 0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_after: got %b want 1", in_ready); end
    $display("test_backpressure: held 5 cycles, released");
  endtask

  task automatic test_gating();
    int n;
    expand_key(KEY_B);
    key_ready = 1'b0;
    in_data   = brev(PT_B);
    in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL gate_in_ready[%0d]: got %b want 0", c, in_ready); end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL gate_busy[%0d]: got %b want 0", c, busy); end
    end
    key_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL gate_in_ready_up: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL gate_accepted: got busy=%b want 1", busy); end
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    total++; if (n !== LAT) begin bad++; $display("FAIL gate_latency: got %0d want %0d", n, LAT); end
    total++; if (out_data !== brev(CT_B)) begin bad++; $display("FAIL gate_data: got %h want %h", brev(out_data), CT_B); end
    tick();
    $display("test_gating: accepted after key_ready");
  endtask

  task automatic test_reset_mid();
    int n;
    expand_key(KEY_C);
    in_data  = brev(PT_C);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (rk_idx !== 4'd5 && n < 50) begin tick(); n++; end
    total++; if (rk_idx !== 4'd5) begin bad++; $display("FAIL rmid_reach_rnd5: got %0d want 5", rk_idx); end
    rst = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    total++; if (rk_idx !== 4'd0) begin bad++; $display("FAIL rmid_rk_idx: got %0d want 0", rk_idx); end
    total++; if (out_data !== 128'h0) begin bad++; $display("FAIL rmid_out_data: got %h want 0", out_data); end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_spurious[%0d]: got ov=%b busy=%b want 0 0", c, out_valid, busy); end
    end
    accept_and_wait(PT_C, n);
    total++; if (n !== LAT) begin bad++; $display("FAIL rmid_latency: got %0d want %0d", n, LAT); end
    total++; if (out_data !== brev(CT_C)) begin bad++; $display("FAIL rmid_data: got %h want %h", brev(out_data), CT_C); end
    tick();
    $display("test_reset_mid: block dropped, next block %h", CT_C);
  endtask

  task automatic test_back_to_back();
    int t_out [2];
    logic [127:0] d_out [2];
    int nout, acc;
    expand_key(KEY_B);
    in_data   = brev(PT_B);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    nout = 0; acc = 0;
    t_out[0] = 0; t_out[1] = 0; d_out[0] = '0; d_out[1] = '0;
    for (int cyc = 0; cyc < 80 && nout < 2; cyc++) begin
      if (out_valid) begin
        t_out[nout] = cyc;
        d_out[nout] = out_data;
        nout++;
      end
      if (in_ready && in_valid) acc++;
      tick();
      if (acc == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    total++; if (nout !== 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", nout); end
    total++; if (t_out[1] - t_out[0] !== PERIOD) begin bad++; $display("FAIL b2b_gap: got %0d want %0d", t_out[1] - t_out[0], PERIOD); end
    total++; if (d_out[0] !== brev(CT_B)) begin bad++; $display("FAIL b2b_data0: got %h want %h", brev(d_out[0]), CT_B); end
    total++; if (d_out[1] !== brev(CT_B)) begin bad++; $display("FAIL b2b_data1: got %h want %h", brev(d_out[1]), CT_B); end
    for (int c = 0; c < 60 && busy; c++) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_drain: got busy=%b want 0", busy); end
    $display("test_back_to_back: outputs at %0d and %0d", t_out[0], t_out[1]);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; key_ready = 1'b0; out_ready = 1'b1;
    build_sbox();
    expand_key(KEY_B);
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_backpressure();
    test_gating();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
